bp_burst_to_wormhole: RTL
=========================

// Module: bp_burst_to_wormhole
// PURPOSE
//  Converts a BedRock Burst stream (header, then optional data beats) into a wormhole router
//  flit stream, without buffering a whole message. Sits at a network injection point,
//  feeding a wormhole router or concentrator, and pairs with the wormhole-to-burst receiver.
//  Output packet layout on the link, first flit first:
//    header flits {pr_hdr, len, cord}, then data flits.
// PARAMETERS
//  flit_width_p    "inv"  link flit width in bits
//  cord_width_p    0      width of the destination {y,x} coordinate field at pr_hdr_i[0+:cord]
//  len_width_p     "inv"  width of the wormhole len field at pr_hdr_i[cord_width_p+:len_width_p];
//                         the field holds the number of flits after the first
//  cid_width_p     0      width of the concentrator id field
//  pr_hdr_width_p  "inv"  width of the protocol header
//  pr_data_width_p "inv"  width of one protocol data beat
//  hdr_width_p     cord+len+cid+pr_hdr  full header width; must be a multiple of flit_width_p
// PORTS
//  clk_i               in   1           clock
//  reset_n_i           in   1           synchronous active-low reset
//  pr_hdr_i            in   hdr_width_p wormhole+protocol header; len field precomputed by sender
//  pr_hdr_v_i          in   1           header valid
//  pr_hdr_ready_and_o  out  1           header consumed (ready&valid handshake)
//  pr_has_data_i       in   1           message carries data; sampled with the header
//  pr_data_i           in   pr_data_width_p  protocol data beat
//  pr_data_v_i         in   1           data valid
//  pr_data_ready_and_o out  1           data beat consumed
//  pr_last_data_i      in   1           current beat is the final beat of the message
//  link_data_o         out  flit_width_p flit to the network
//  link_v_o            out  1           flit valid
//  link_ready_and_i    in   1           network accepts flit
//  err_o               out  1           sticky length mismatch (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: all state uses clk_i. Reset is synchronous and active-low (reset_n_i).
//  - Constants: hdr_len = hdr_width_p/flit_width_p.
//    Legal widths: pr_data_width_p%flit_width_p==0 (wide), or flit_width_p%pr_data_width_p==0 (narrow).
//  - Reset (reset_n_i==0 at posedge):
//    - FSM -> e_hdr; flit and beat counters -> 0; pack register cleared; err_o -> 0.
//    - link_v_o, pr_hdr_ready_and_o and pr_data_ready_and_o are forced to 0 while reset_n_i==0.
//    - Reset mid-message: the partial packet is abandoned; no further flits of it are emitted.
//  - FSM e_hdr:
//    - link_data_o = pr_hdr_i slice [hdr_cnt*flit +: flit].
//    - link_v_o = pr_hdr_v_i. This is a combinational passthrough with 0-cycle latency.
//    - hdr_cnt increments on link_v_o & link_ready_and_i.
//    - On acceptance of flit hdr_len-1: pr_hdr_ready_and_o=1 in that cycle (only then), and
//      hdr_cnt wraps to 0.
//    - Next state is e_data if pr_has_data_i, else e_hdr. A back-to-back header may follow the
//      next cycle.
//  - FSM e_data, wide (data_len = pr_data_width_p/flit_width_p):
//    - Passthrough PISO. Flit = pr_data_i slice [dat_cnt*flit +: flit]; link_v_o = pr_data_v_i.
//    - pr_data_ready_and_o = link_ready_and_i on slice data_len-1, else 0.
//    - Beat consumed with pr_last_data_i -> e_hdr.
//  - FSM e_data, narrow (els = flit_width_p/pr_data_width_p):
//    - Beats are stored into slot pk_cnt of a pack register. pr_data_ready_and_o = 1 while
//      pk_cnt<els-1 and ~pr_last_data_i.
//    - On beat pk_cnt==els-1 or pr_last_data_i, the beat is passed through:
//      flit = {pr_data_i, pack_r} at its slot; link_v_o = pr_data_v_i; unfilled upper slots = 0.
//    - On that beat, pr_data_ready_and_o = link_ready_and_i; pk_cnt -> 0.
//    - A consumed last beat returns the FSM to e_hdr.
//  - Link protocol rules:
//    - link_data_o is held stable while link_v_o & ~link_ready_and_i.
//    - No flit is dropped or duplicated under arbitrary link backpressure.
//  - Flit counter: counts every flit emitted (header and data).
//    Packet end = last data flit, or the last header flit when has_data==0.
// CONFIGURATION
//  BP_BURST_TO_WORMHOLE_LEN_CHECK_EN defined:
//    - At packet end, the emitted flit count minus 1 is compared to the len field latched from
//      the header.
//    - On mismatch, err_o is set to 1 the following cycle and holds until reset.
//    - Checker state resets with reset_n_i.
//  Not defined: err_o tied to 0; no latch or compare logic is instantiated.
// TESTING
//  1. Header-only message, flit=64, hdr=128, has_data=0, len=1 ->
//     2 flits (hdr[63:0], hdr[127:64]); pr_hdr_ready_and_o pulses once, with flit 2.
//  2. Wide case, flit=64, data=512, 1 beat with last=1, len=9 ->
//     2 header flits then 8 data flits, low slice first; single pr_data_ready_and_o pulse.
//  3. Narrow case, flit=128, data=32, 3 beats 0xA,0xB,0xC with last on 0xC ->
//     1 data flit = {32'h0,0xC,0xB,0xA}.
//  4. Random link_ready_and_i at 30% duty on test 2 ->
//     identical flit sequence; link_data_o stable whenever stalled.
//  5. reset_n_i=0 for 1 cycle after 4 data flits of test 2 ->
//     link_v_o=0 during reset; the next header is emitted as a fresh packet; err_o=0.
//  6. LEN_CHECK_EN defined, header len=5 with 1 wide beat (actual 9) -> err_o=1 from the cycle
//     after the final flit; with the macro undefined -> err_o=0.

Source files
------------

// File: rtl/bp_burst_to_wormhole.sv
// Converts a BedRock Burst stream (header + optional data beats) into wormhole flits.
// Latency: 0 cycles, flits are combinational slices of the presented header/beat.
// Backpressure: input ready follows link_ready_and_i on the last slice. Narrow beats are absorbed into a pack register.
// Optional sticky length checker: define BP_BURST_TO_WORMHOLE_LEN_CHECK_EN.
module bp_burst_to_wormhole #(
    parameter int flit_width_p    = 64,
    parameter int cord_width_p    = 0,
    parameter int len_width_p     = 4,
    parameter int cid_width_p     = 0,
    parameter int pr_hdr_width_p  = 124,
    parameter int pr_data_width_p = 512,
    parameter int hdr_width_p     = cord_width_p + len_width_p + cid_width_p + pr_hdr_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [hdr_width_p-1:0]     pr_hdr_i,
    input  logic                       pr_hdr_v_i,
    output logic                       pr_hdr_ready_and_o,
    input  logic                       pr_has_data_i,
    input  logic [pr_data_width_p-1:0] pr_data_i,
    input  logic                       pr_data_v_i,
    output logic                       pr_data_ready_and_o,
    input  logic                       pr_last_data_i,
    output logic [flit_width_p-1:0]    link_data_o,
    output logic                       link_v_o,
    input  logic                       link_ready_and_i,
    output logic                       err_o
);
    localparam int hdr_len = hdr_width_p / flit_width_p;
    localparam int HCW = (hdr_len > 1) ? $clog2(hdr_len) : 1;
    localparam logic [HCW-1:0] HDR_LAST = HCW'(hdr_len - 1);

    typedef enum logic {e_hdr, e_data} state_e;

    state_e                  state_r, state_n;
    logic [HCW-1:0]          hdr_cnt_r;
    logic [flit_width_p-1:0] dat_flit;
    logic                    dat_v, dat_rdy;
    logic                    link_fire, in_data;

    assign link_fire = link_v_o & link_ready_and_i;
    assign in_data   = (state_r == e_data);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r   <= e_hdr;
            hdr_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (!in_data && link_fire)
                hdr_cnt_r <= (hdr_cnt_r == HDR_LAST) ? '0 : hdr_cnt_r + 1'b1;
        end
    end

    always_comb begin
        state_n             = state_r;
        link_data_o         = '0;
        link_v_o            = 1'b0;
        pr_hdr_ready_and_o  = 1'b0;
        pr_data_ready_and_o = 1'b0;
        if (reset_n_i) begin
            case (state_r)
                e_hdr: begin
                    link_data_o        = pr_hdr_i[int'(hdr_cnt_r)*flit_width_p +: flit_width_p];
                    link_v_o           = pr_hdr_v_i;
                    pr_hdr_ready_and_o = pr_hdr_v_i & link_ready_and_i & (hdr_cnt_r == HDR_LAST);
                    if (pr_hdr_ready_and_o)
                        state_n = pr_has_data_i ? e_data : e_hdr;
                end
                default: begin
                    link_data_o         = dat_flit;
                    link_v_o            = dat_v;
                    pr_data_ready_and_o = dat_rdy;
                    if (pr_data_v_i && dat_rdy && pr_last_data_i)
                        state_n = e_hdr;
                end
            endcase
        end
    end

    if (pr_data_width_p >= flit_width_p) begin : g_wide
        localparam int data_len = pr_data_width_p / flit_width_p;
        localparam int DCW = (data_len > 1) ? $clog2(data_len) : 1;
        localparam logic [DCW-1:0] DAT_LAST = DCW'(data_len - 1);

        logic [DCW-1:0] dat_cnt_r;

        assign dat_flit = pr_data_i[int'(dat_cnt_r)*flit_width_p +: flit_width_p];
        assign dat_v    = pr_data_v_i;
        assign dat_rdy  = link_ready_and_i & (dat_cnt_r == DAT_LAST);

        always_ff @(posedge clk_i) begin
            if (!reset_n_i)
                dat_cnt_r <= '0;
            else if (in_data && link_fire)
                dat_cnt_r <= (dat_cnt_r == DAT_LAST) ? '0 : dat_cnt_r + 1'b1;
        end
    end else begin : g_narrow
        localparam int els = flit_width_p / pr_data_width_p;
        localparam int PCW = $clog2(els);
        localparam logic [PCW-1:0] PK_LAST = PCW'(els - 1);

        logic [els-1:0][pr_data_width_p-1:0] pack_r, pack_out;
        logic [PCW-1:0]                      pk_cnt_r;
        logic                                pass;

        // A beat is forwarded when it fills the flit or ends the message.
        assign pass     = (pk_cnt_r == PK_LAST) | pr_last_data_i;
        assign dat_flit = pack_out;
        assign dat_v    = pr_data_v_i & pass;
        assign dat_rdy  = pass ? link_ready_and_i : 1'b1;

        always_comb begin
            pack_out = '0;
            for (int i = 0; i < els; i++) begin
                if (i < int'(pk_cnt_r))
                    pack_out[i] = pack_r[i];
                else if (i == int'(pk_cnt_r))
                    pack_out[i] = pr_data_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                pack_r   <= '0;
                pk_cnt_r <= '0;
            end else if (in_data && pr_data_v_i && dat_rdy) begin
                if (pass) begin
                    pk_cnt_r <= '0;
                end else begin
                    pack_r[pk_cnt_r] <= pr_data_i;
                    pk_cnt_r         <= pk_cnt_r + 1'b1;
                end
            end
        end
    end

`ifdef BP_BURST_TO_WORMHOLE_LEN_CHECK_EN
    logic [len_width_p-1:0] len_r, cur_len;
    logic [len_width_p:0]   flit_cnt_r;
    logic                   err_r, pkt_end;

    // Header-only packets end on their own header, so the len field is still live on the input.
    assign cur_len = in_data ? len_r : pr_hdr_i[cord_width_p +: len_width_p];
    assign pkt_end = (pr_hdr_ready_and_o & ~pr_has_data_i)
                   | (pr_data_v_i & pr_data_ready_and_o & pr_last_data_i);
    assign err_o   = err_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            len_r      <= '0;
            flit_cnt_r <= '0;
            err_r      <= 1'b0;
        end else begin
            if (pr_hdr_ready_and_o)
                len_r <= pr_hdr_i[cord_width_p +: len_width_p];
            if (pkt_end) begin
                flit_cnt_r <= '0;
                if (flit_cnt_r != {1'b0, cur_len})
                    err_r <= 1'b1;
            end else if (link_fire && flit_cnt_r != '1) begin
                flit_cnt_r <= flit_cnt_r + 1'b1;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif
endmodule
